conv_bf16tomxint: RTL
=====================

# conv_bf16tomxint

Streaming quantiser from bf16 into an MXINT block: a shared power-of-two scale (E8M0) plus `block_size` signed fixed-point elements. It is the inverse-direction partner of the fixed-point→bf16 converter. It sits between bf16 producers (accumulators, activations) and MX-format storage and compute. It buffers one full block to find the maximum exponent, then drains the quantised elements with a valid/ready handshake.

## Interface

Parameters:

- `block_size`, 32: elements per MX block, ≥2.
- `bit_width`, 8: element width, range 4–9; two's complement with `bit_width-2` fractional bits.

Ports:

- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  input element valid.
- `o_ready`  out  1  block accepts input.
- `i_bf16`  in  16  bf16 element {sign, exp[7:0], man[6:0]}.
- `o_valid`  out  1  output element valid.
- `i_ready`  in  1  downstream accepts output.
- `o_fi_num`  out  bit_width  quantised element.
- `o_scale`  out  8  shared E8M0 exponent, bias 127, constant for the whole block.
- `o_last`  out  1  marks the final element of the block.

## Operation

- Two-state FSM:
  - FILL: `o_ready`=1, `o_valid`=0. Each `i_valid&&o_ready` writes `i_bf16` to `buf[wr_idx]`, increments `wr_idx` and updates the running maximum `emax`. On the `block_size`-th accept the FSM goes to DRAIN.
  - DRAIN: `o_ready`=0, `o_valid`=1, `i_valid` ignored. Each `o_valid&&i_ready` increments `rd_idx`. The accept with `o_last`=1 returns the FSM to FILL and clears `wr_idx`, `rd_idx` and `emax`.
- `emax` = max biased exponent over the block. Subnormals (exp=0) count as 0 and are flushed to zero.
- Special values: if any element has exp=255 (Inf/NaN), `o_scale`=0xFF and every element of that block is 0.
- `o_scale` = `emax`. An all-zero or all-subnormal block gives 0x00 with all elements 0.
- Element conversion, from `buf[rd_idx]` with exponent e≠0:
  - Magnitude source is the 8-bit {1, man}.
  - Right shift is sh = (emax − e) + 9 − `bit_width`.
  - Shifted-out bits form R (first dropped bit) and S (OR of the rest). Round half to even: increment if R && (LSB || S).
  - sh ≥ 10 yields 0.
  - Clamp the magnitude to 2^(`bit_width`−1)−1, then negate if sign=1. Result range is symmetric.
  - −0 and zero magnitude after rounding output 0.
- `o_fi_num`, `o_scale` and `o_last` are combinational from registered state (`buf`, `rd_idx`, `emax`, special flag) and stay stable while stalled.
- `o_last` = DRAIN && (`rd_idx` == `block_size`−1).

## Timing

- Reset values: FSM=FILL, `o_ready`=1 in the cycle after reset is sampled (0 while `i_rst`=1), `o_valid`=0, `o_last`=0, `o_fi_num`=0, `o_scale`=0. Indices, `emax` and special flag are cleared. Buffer contents are don't-care.
- Latency: element 0 is presented (`o_valid`=1) in the cycle after the last input accept.
- No overlap of fill and drain. Minimum period is 2×`block_size` cycles per block.
- Handshake: data transfers on the rising edge with valid&&ready. `o_valid` never drops without a transfer, and output data does not change while `o_valid`&&!`i_ready`.
- Reset mid-FILL or mid-DRAIN discards the partial block. The next block starts fresh from the cycle after reset.
- Index wrap: `wr_idx` and `rd_idx` return to 0 at the FILL/DRAIN boundary, never by modular overflow.

## Test plan

All scenarios use `block_size`=4, `bit_width`=8.

- Basic block: inputs 0x3F80, 0x4000, 0xBF00, 0x0000 (1.0, 2.0, −0.5, 0). Required: `o_scale`=0x80; elements 0x20, 0x40, 0xF0, 0x00; `o_last` on the 4th.
- Saturation: inputs 0x3FFF, 0x3F80, 0x3F80, 0x3F80. Required: `o_scale`=0x7F; elements 0x7F (127.5 rounds to 128, clamped), 0x40, 0x40, 0x40. Repeat with 0xBFFF: first element 0x81.
- RNE ties: inputs 0x4300, 0x3F80, 0x3FC0, 0x4040. Required: `o_scale`=0x86; elements 0x40, 0x00 (0.5→0), 0x01 (0.75), 0x02 (1.5→2).
- Specials: block {0x7F80, 0x3F80, 0, 0} gives `o_scale`=0xFF with all elements 0. Block {0x0001, 0x8000, 0, 0} gives `o_scale`=0x00 with all elements 0.
- Backpressure: hold `i_ready`=0 for 3 cycles at element 1 while toggling `i_valid`. Required: `o_fi_num` and `o_last` unchanged, `o_ready`=0, no extra input accepted, no element lost or duplicated.
- Reset mid-fill: accept 2 elements, pulse `i_rst` for 1 cycle, then feed the basic block. Required: output matches the basic-block result exactly, and `o_ready`=0 during the reset cycle.

Source files
------------

// File: rtl/conv_bf16tomxint_if.sv
// conv_bf16tomxint_if
//   Handshake bundle between a bf16 producer, the bf16->MXINT quantiser and
//   the MX-format consumer.
//   Upstream side  : i_valid / o_ready / i_bf16
//   Downstream side: o_valid / i_ready / o_fi_num / o_scale / o_last
//   The "slave" modport is the quantiser's view; "master" is the view of
//   the environment that drives the stream and consumes the block.
interface conv_bf16tomxint_if #(
  parameter int bit_width = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [15:0]          i_bf16;
  logic                 o_valid;
  logic                 i_ready;
  logic [bit_width-1:0] o_fi_num;
  logic [7:0]           o_scale;
  logic                 o_last;

  modport slave (
    input  i_valid, i_bf16, i_ready,
    output o_ready, o_valid, o_fi_num, o_scale, o_last
  );

  modport master (
    output i_valid, i_bf16, i_ready,
    input  o_ready, o_valid, o_fi_num, o_scale, o_last
  );
endinterface

// File: rtl/conv_bf16tomxint.sv
// conv_bf16tomxint
//   Streaming bf16 -> MXINT quantiser. Buffers one block of block_size bf16
//   elements while tracking the largest biased exponent, then drains the
//   block as bit_width-bit two's complement elements (bit_width-2 fractional
//   bits) sharing one E8M0 scale.
//   Ports:
//     i_clk       clock
//     i_rst       synchronous active-high reset
//     bus.i_valid / bus.o_ready / bus.i_bf16     input element stream
//     bus.o_valid / bus.i_ready                  output handshake
//     bus.o_fi_num                               quantised element
//     bus.o_scale                                shared exponent (bias 127)
//     bus.o_last                                 final element of the block
module conv_bf16tomxint #(
  parameter int block_size = 32,
  parameter int bit_width  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  conv_bf16tomxint_if.slave  bus
);

  localparam int                   IDX_W     = $clog2(block_size);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(block_size - 1);
  // Extra right shift that places {1,man} (binary point after the leading 1)
  // onto an element with bit_width-2 fractional bits.
  localparam logic [9:0]           SH_BIAS   = 10'(9 - bit_width);
  localparam logic [8:0]           MAG_MAX   = 9'((1 << (bit_width - 1)) - 1);
  localparam logic [bit_width-1:0] MAG_MAX_W = bit_width'((1 << (bit_width - 1)) - 1);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     wr_idx_q;
  logic [IDX_W-1:0]     rd_idx_q;
  logic [7:0]           emax_q;
  logic                 special_q;
  logic                 ready_q;
  logic                 valid_q;
  logic [15:0]          buf_q [block_size];

  logic                 accept_s;
  logic [7:0]           exp_in_s;
  logic [15:0]          elem_s;
  logic [7:0]           exp_s;
  logic [7:0]           mag_s;
  logic [9:0]           sh_s;
  logic [17:0]          ext_s;
  logic                 rnd_s;
  logic [8:0]           qr_s;
  logic [bit_width-1:0] clamp_s;
  logic [bit_width-1:0] neg_s;
  logic [bit_width-1:0] fi_s;

  assign exp_in_s = bus.i_bf16[14:7];
  assign accept_s = (state_q == S_FILL) && bus.i_valid && !i_rst;

  // Block buffer; contents are only meaningful between fill and drain.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      buf_q[wr_idx_q] <= bus.i_bf16;
    end
  end

  // Fill/drain controller with running max exponent and special flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_FILL;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      emax_q    <= 8'd0;
      special_q <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (bus.i_valid) begin
            if (exp_in_s > emax_q) begin
              emax_q <= exp_in_s;
            end
            if (exp_in_s == 8'hFF) begin
              special_q <= 1'b1;
            end
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_q <= '0;
              state_q  <= S_DRAIN;
              ready_q  <= 1'b0;
              valid_q  <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.i_ready) begin
            if (rd_idx_q == LAST_IDX) begin
              state_q   <= S_FILL;
              rd_idx_q  <= '0;
              wr_idx_q  <= '0;
              emax_q    <= 8'd0;
              special_q <= 1'b0;
              ready_q   <= 1'b1;
              valid_q   <= 1'b0;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= S_FILL;
          wr_idx_q  <= '0;
          rd_idx_q  <= '0;
          emax_q    <= 8'd0;
          special_q <= 1'b0;
          ready_q   <= 1'b1;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  // Quantise the element at rd_idx against the block exponent.
  always_comb begin
    elem_s = buf_q[rd_idx_q];
    exp_s  = elem_s[14:7];
    mag_s  = {1'b1, elem_s[6:0]};
    // emax >= exp for every element of a filled block, so no underflow.
    sh_s   = {2'b00, emax_q} - {2'b00, exp_s} + SH_BIAS;
    // Ten guard positions below the magnitude keep R and S for any sh < 10.
    ext_s  = {mag_s, 10'd0} >> sh_s;
    rnd_s  = ext_s[9] & (ext_s[10] | (|ext_s[8:0]));
    qr_s   = {1'b0, ext_s[17:10]} + {8'd0, rnd_s};
    if (qr_s > MAG_MAX) begin
      clamp_s = MAG_MAX_W;
    end else begin
      clamp_s = qr_s[bit_width-1:0];
    end
    neg_s = {bit_width{1'b0}} - clamp_s;
    // Outside DRAIN the buffer may hold garbage; present a clean zero.
    if (!valid_q || special_q || (exp_s == 8'd0) || (sh_s >= 10'd10)) begin
      fi_s = {bit_width{1'b0}};
    end else if (elem_s[15]) begin
      fi_s = neg_s;
    end else begin
      fi_s = clamp_s;
    end
  end

  // o_ready drops while reset is asserted so nothing is taken in that cycle.
  assign bus.o_ready  = ready_q & ~i_rst;
  assign bus.o_valid  = valid_q;
  assign bus.o_last   = valid_q && (rd_idx_q == LAST_IDX);
  assign bus.o_fi_num = fi_s;
  assign bus.o_scale  = !valid_q ? 8'h00 : (special_q ? 8'hFF : emax_q);

endmodule
